// File: rtl/arbitro_multiplicador.sv
// Round-robin arbiter/sequencer sharing one 16x16 shift-add multiplier among N requesters.
// Build macro ARB_ZERO_BYPASS_EN: a zero operand skips the multiplier and completes in one DONE cycle.
module arbitro_multiplicador #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N-1:0]     Req,
  input  logic [N*W-1:0]   Multiplicando_in,
  input  logic [N*W-1:0]   Multiplicador_in,
  output logic [N-1:0]     Ack,
  output logic [N-1:0]     Valid,
  output logic [2*W-1:0]   Resultado,
  output logic             Erro,
  output logic             Busy,
  output logic             Mul_St,
  output logic [W-1:0]     Mul_A,
  output logic [W-1:0]     Mul_B,
  input  logic             Mul_Done,
  input  logic             Mul_Idle,
  input  logic [2*W-1:0]   Mul_Produto
);

  localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_id_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_armed;
  logic             w_armed_nxt;

  logic [N-1:0]     r_ack;
  logic [N-1:0]     w_ack_nxt;
  logic [N-1:0]     r_valid;
  logic [N-1:0]     w_valid_nxt;
  logic [2*W-1:0]   r_resultado;
  logic [2*W-1:0]   w_resultado_nxt;
  logic             r_erro;
  logic             w_erro_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_mul_st;
  logic             w_mul_st_nxt;
  logic [W-1:0]     r_mul_a;
  logic [W-1:0]     w_mul_a_nxt;
  logic [W-1:0]     r_mul_b;
  logic [W-1:0]     w_mul_b_nxt;

  logic [ID_W:0]    w_pick;
  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic [W-1:0]     w_win_a;
  logic [W-1:0]     w_win_b;
  logic             w_unused_mul_idle;

  function automatic logic [N-1:0] f_onehot(input logic [ID_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan upward from ptr with wrap; returns {found, winner}.
  function automatic logic [ID_W:0] f_rr_pick(input logic [ID_W-1:0] ptr,
                                              input logic [N-1:0]    req);
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < N; off++) begin
      sum   = {1'b0, ptr} + (ID_W+1)'(off);
      sum   = (sum >= (ID_W+1)'(N)) ? (sum - (ID_W+1)'(N)) : sum;
      idx   = sum[ID_W-1:0];
      win   = (!found && req[idx]) ? idx : win;
      found = found | req[idx];
    end
    return {found, win};
  endfunction

  assign w_pick            = f_rr_pick(r_ptr, Req);
  assign w_found           = w_pick[ID_W];
  assign w_win             = w_pick[ID_W-1:0];
  assign w_win_a           = Multiplicando_in[w_win*W +: W];
  assign w_win_b           = Multiplicador_in[w_win*W +: W];
  assign w_cnt_inc         = r_cnt + 1'b1;
  assign w_unused_mul_idle = Mul_Idle;

`ifdef ARB_ZERO_BYPASS_EN
  logic w_zero_op;
  assign w_zero_op = (w_win_a == '0) || (w_win_b == '0);
`endif

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_id_nxt        = r_id;
    w_cnt_nxt       = r_cnt;
    w_armed_nxt     = r_armed;
    w_ack_nxt       = '0;
    w_valid_nxt     = '0;
    w_resultado_nxt = r_resultado;
    w_erro_nxt      = 1'b0;
    w_mul_st_nxt    = 1'b0;
    w_mul_a_nxt     = r_mul_a;
    w_mul_b_nxt     = r_mul_b;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_id_nxt    = w_win;
          w_mul_a_nxt = w_win_a;
          w_mul_b_nxt = w_win_b;
          w_ack_nxt   = f_onehot(w_win);
`ifdef ARB_ZERO_BYPASS_EN
          if (w_zero_op) begin
            w_valid_nxt     = f_onehot(w_win);
            w_resultado_nxt = '0;
            w_state_nxt     = S_DONE;
          end else begin
            w_mul_st_nxt = 1'b1;
            w_state_nxt  = S_START;
          end
`else
          w_mul_st_nxt = 1'b1;
          w_state_nxt  = S_START;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_START: begin
        w_armed_nxt = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        // A Done seen before any low cycle is left over from the previous operation.
        w_armed_nxt = r_armed | ~Mul_Done;
        if (r_armed && Mul_Done) begin
          w_resultado_nxt = Mul_Produto;
          w_valid_nxt     = f_onehot(r_id);
          w_state_nxt     = S_DONE;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
          w_cnt_nxt       = w_cnt_inc;
          w_resultado_nxt = '0;
          w_erro_nxt      = 1'b1;
          w_valid_nxt     = f_onehot(r_id);
          w_state_nxt     = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_DONE: begin
        w_ptr_nxt   = (r_id == ID_W'(N - 1)) ? '0 : (r_id + 1'b1);
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control, datapath and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_ack       <= '0;
      r_valid     <= '0;
      r_resultado <= '0;
      r_erro      <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_st    <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_id        <= w_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_armed     <= w_armed_nxt;
      r_ack       <= w_ack_nxt;
      r_valid     <= w_valid_nxt;
      r_resultado <= w_resultado_nxt;
      r_erro      <= w_erro_nxt;
      r_busy      <= w_busy_nxt;
      r_mul_st    <= w_mul_st_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
    end
  end

  assign Ack       = r_ack;
  assign Valid     = r_valid;
  assign Resultado = r_resultado;
  assign Erro      = r_erro;
  assign Busy      = r_busy;
  assign Mul_St    = r_mul_st;
  assign Mul_A     = r_mul_a;
  assign Mul_B     = r_mul_b;

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Directed self-checking bench for arbitro_multiplicador with a behavioural multiplier stand-in
// and a scoreboard of expected results/grants.
module tb_arbitro_multiplicador;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic [N-1:0]   Req;
  logic [N*W-1:0] mcand;
  logic [N*W-1:0] mplier;
  logic [N-1:0]   Ack;
  logic [N-1:0]   Valid;
  logic [2*W-1:0] Resultado;
  logic           Erro;
  logic           Busy;
  logic           Mul_St;
  logic [W-1:0]   Mul_A;
  logic [W-1:0]   Mul_B;
  logic           mul_done;
  logic           mul_idle;
  logic [2*W-1:0] mul_prod;

  arbitro_multiplicador #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Req              (Req),
    .Multiplicando_in (mcand),
    .Multiplicador_in (mplier),
    .Ack              (Ack),
    .Valid            (Valid),
    .Resultado        (Resultado),
    .Erro             (Erro),
    .Busy             (Busy),
    .Mul_St           (Mul_St),
    .Mul_A            (Mul_A),
    .Mul_B            (Mul_B),
    .Mul_Done         (mul_done),
    .Mul_Idle         (mul_idle),
    .Mul_Produto      (mul_prod)
  );

  always #5 Clk = ~Clk;

  int cyc_cnt = 0;
  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  // Multiplier stand-in: optional stale Done after St, completion after mul_delay cycles.
  int          mul_delay = 4;
  int          stale_cfg = 0;
  bit          never     = 1'b0;
  int          m_cnt;
  int          m_stale;
  logic [31:0] m_pend;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mul_done <= 1'b0;
      mul_prod <= '0;
      m_cnt    <= 0;
      m_stale  <= 0;
      m_pend   <= '0;
    end else if (Mul_St) begin
      m_cnt    <= mul_delay;
      m_stale  <= stale_cfg;
      m_pend   <= 32'(Mul_A) * 32'(Mul_B);
      mul_done <= (stale_cfg != 0) ? mul_done : 1'b0;
    end else if (m_stale != 0) begin
      m_stale <= m_stale - 1;
      if (m_stale == 1) mul_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !never) begin
        mul_done <= 1'b1;
        mul_prod <= m_pend;
      end
    end
  end
  assign mul_idle = (m_cnt == 0);

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        erro;
    logic [15:0] a;
    logic [15:0] b;
    bit          chk_ops;
  } exp_t;

  exp_t sb_q[$];
  int   ack_q[$];

  int n_err    = 0;
  int n_checks = 0;
  int st_cyc   = 0;
  int ack_cyc  = 0;
  int valid_cyc = 0;
  int n_st     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    mcand[i*W +: W]  = a;
    mplier[i*W +: W] = b;
  endtask

  task automatic expect_txn(input int id, input logic [31:0] res, input logic erro, input bit chk_ops);
    exp_t e;
    e.id      = id;
    e.res     = res;
    e.erro    = erro;
    e.a       = mcand[id*W +: W];
    e.b       = mplier[id*W +: W];
    e.chk_ops = chk_ops;
    sb_q.push_back(e);
  endtask

  // Observe n results within a cycle budget, checking grants and results against the queues.
  task automatic run_txns(input int n, input int budget, input bit drop_on_ack);
    int   got = 0;
    int   a;
    exp_t e;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge Clk);
      if (Mul_St) begin
        n_st++;
        st_cyc = cyc_cnt;
      end
      if (Ack != '0) begin
        ack_cyc = cyc_cnt;
        chk("ack_onehot", 64'($countones(Ack)), 64'd1);
        if (ack_q.size() != 0) begin
          a = ack_q.pop_front();
          chk("ack_order", 64'(Ack), 64'(oh(a)));
        end else begin
          chk("ack_unexpected", 64'(Ack), 64'd0);
        end
        if (drop_on_ack) Req = Req & ~Ack;
      end
      if (Valid != '0) begin
        valid_cyc = cyc_cnt;
        got++;
        chk("valid_onehot", 64'($countones(Valid)), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("valid_id", 64'(Valid), 64'(oh(e.id)));
          chk("resultado", 64'(Resultado), 64'(e.res));
          chk("erro", 64'(Erro), 64'(e.erro));
          if (e.chk_ops) begin
            chk("mul_a_held", 64'(Mul_A), 64'(e.a));
            chk("mul_b_held", 64'(Mul_B), 64'(e.b));
          end
        end else begin
          chk("valid_unexpected", 64'(Valid), 64'd0);
        end
      end
    end
    chk("txn_count", 64'(got), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc;
    int st0;
    int n_seen;
    bit got_ack;

    Rst_n  = 1'b0;
    Req    = '0;
    mcand  = '0;
    mplier = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ack",   64'(Ack), 64'd0);
    chk("rst_valid", 64'(Valid), 64'd0);
    chk("rst_res",   64'(Resultado), 64'd0);
    chk("rst_erro",  64'(Erro), 64'd0);
    chk("rst_busy",  64'(Busy), 64'd0);
    chk("rst_st",    64'(Mul_St), 64'd0);
    chk("rst_mul_a", 64'(Mul_A), 64'd0);
    chk("rst_mul_b", 64'(Mul_B), 64'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Requesters 1 and 3 together from ptr=0.
    set_ops(1, 16'd200, 16'd3);
    set_ops(3, 16'd7, 16'd9);
    expect_txn(1, 32'd600, 1'b0, 1'b1);
    expect_txn(3, 32'd63, 1'b0, 1'b1);
    ack_q.push_back(1);
    ack_q.push_back(3);
    Req = 4'b1010;
    run_txns(2, 200, 1'b1);
    repeat (2) @(negedge Clk);

    // All four held high: order 0,1,2,3,0,1,2,3 proves ptr returned to 0.
    set_ops(0, 16'd3, 16'd5);
    set_ops(1, 16'd11, 16'd13);
    set_ops(2, 16'd100, 16'd100);
    set_ops(3, 16'hFFFF, 16'hFFFF);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        expect_txn(i, 32'(mcand[i*W +: W]) * 32'(mplier[i*W +: W]), 1'b0, 1'b1);
        ack_q.push_back(i);
      end
    end
    Req = 4'b1111;
    run_txns(8, 400, 1'b0);
    Req = '0;
    repeat (2) @(negedge Clk);

    // Single request, requester 0, with latency checks.
    set_ops(0, 16'd12, 16'd10);
    expect_txn(0, 32'd120, 1'b0, 1'b1);
    ack_q.push_back(0);
    st0     = n_st;
    req_cyc = cyc_cnt;
    Req     = 4'b0001;
    run_txns(1, 100, 1'b1);
    chk("t1_ack_latency", 64'(ack_cyc - req_cyc), 64'd1);
    chk("t1_st_with_ack", 64'(st_cyc), 64'(ack_cyc));
    chk("t1_one_st", 64'(n_st - st0), 64'd1);
    chk("t1_valid_latency", 64'(valid_cyc - st_cyc), 64'(mul_delay + 2));
    repeat (2) @(negedge Clk);

    // Stale Done left high from previous op: result must be the new product.
    stale_cfg = 3;
    mul_delay = 6;
    set_ops(2, 16'd1000, 16'd7);
    expect_txn(2, 32'd7000, 1'b0, 1'b1);
    ack_q.push_back(2);
    Req = 4'b0100;
    run_txns(1, 100, 1'b1);
    chk("stale_latency", 64'(valid_cyc - st_cyc), 64'(3 + 6 + 2));
    stale_cfg = 0;
    mul_delay = 4;
    repeat (2) @(negedge Clk);

    // Multiplier never completes: timeout then a normal request.
    never = 1'b1;
    set_ops(1, 16'd9, 16'd9);
    expect_txn(1, 32'd0, 1'b1, 1'b1);
    ack_q.push_back(1);
    Req = 4'b0010;
    run_txns(1, 200, 1'b1);
    chk("timeout_latency", 64'(valid_cyc - st_cyc), 64'(TO + 1));
    never = 1'b0;
    repeat (2) @(negedge Clk);
    set_ops(3, 16'd5, 16'd7);
    expect_txn(3, 32'd35, 1'b0, 1'b1);
    ack_q.push_back(3);
    Req = 4'b1000;
    run_txns(1, 100, 1'b1);
    repeat (2) @(negedge Clk);

    // Zero operand.
    set_ops(1, 16'd12, 16'd0);
    st0 = n_st;
`ifdef ARB_ZERO_BYPASS_EN
    expect_txn(1, 32'd0, 1'b0, 1'b0);
`else
    expect_txn(1, 32'd0, 1'b0, 1'b1);
`endif
    ack_q.push_back(1);
    Req = 4'b0010;
    run_txns(1, 100, 1'b1);
`ifdef ARB_ZERO_BYPASS_EN
    chk("zero_ack_with_valid", 64'(ack_cyc), 64'(valid_cyc));
    chk("zero_no_st", 64'(n_st - st0), 64'd0);
`else
    chk("zero_one_st", 64'(n_st - st0), 64'd1);
    chk("zero_full_latency", 64'(valid_cyc - st_cyc), 64'(mul_delay + 2));
`endif
    repeat (2) @(negedge Clk);

    // Reset asserted during WAIT.
    mul_delay = 20;
    set_ops(2, 16'd50, 16'd50);
    Req     = 4'b0100;
    got_ack = 1'b0;
    for (int c = 0; c < 10 && !got_ack; c++) begin
      @(negedge Clk);
      if (Ack[2]) got_ack = 1'b1;
    end
    chk("rst_pre_ack", 64'(got_ack), 64'd1);
    Req = '0;
    repeat (3) @(negedge Clk);
    chk("rst_pre_busy", 64'(Busy), 64'd1);
    Rst_n = 1'b0;
    #1;
    chk("mrst_ack",   64'(Ack), 64'd0);
    chk("mrst_valid", 64'(Valid), 64'd0);
    chk("mrst_res",   64'(Resultado), 64'd0);
    chk("mrst_erro",  64'(Erro), 64'd0);
    chk("mrst_busy",  64'(Busy), 64'd0);
    chk("mrst_st",    64'(Mul_St), 64'd0);
    chk("mrst_mul_a", 64'(Mul_A), 64'd0);
    chk("mrst_mul_b", 64'(Mul_B), 64'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    sb_q.delete();
    ack_q.delete();
    n_seen = 0;
    repeat (30) begin
      @(negedge Clk);
      if (Valid != '0) n_seen++;
    end
    chk("mrst_no_valid", 64'(n_seen), 64'd0);
    chk("mrst_idle", 64'(Busy), 64'd0);

    // After reset ptr is 0: requester 0 wins over 2.
    mul_delay = 4;
    set_ops(0, 16'd2, 16'd3);
    set_ops(2, 16'd4, 16'd5);
    expect_txn(0, 32'd6, 1'b0, 1'b1);
    expect_txn(2, 32'd20, 1'b0, 1'b1);
    ack_q.push_back(0);
    ack_q.push_back(2);
    Req = 4'b0101;
    run_txns(2, 200, 1'b1);
    Req = '0;
    repeat (2) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/arbitro_multiplicador.md
# arbitro_multiplicador

Round-robin arbiter and sequencer that shares one `multiplicador` (16x16 shift-add, `St`/`Idle`/`Done`/`Produto`) between N requesters. It latches the winning requester's operands and pulses the multiplier start. It then waits for completion, with a watchdog, and returns the 32-bit product to that requester with a one-cycle valid pulse. It sits between the datapath units that need multiplication and the single multiplier instance.

## Interface
- `N`, default 4: number of requesters (2..8).
- `W`, default 16: operand width; product width is 2W.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Rst_n`  in  1  asynchronous active-low reset.
- `Req`  in  N  per-requester request level; held until the matching `Ack`.
- `Multiplicando_in`  in  N*W  packed operand A; slice i belongs to requester i.
- `Multiplicador_in`  in  N*W  packed operand B; slice i belongs to requester i.
- `Ack`  out  N  one-hot, one-cycle pulse: operands of requester i captured.
- `Valid`  out  N  one-hot, one-cycle pulse: `Resultado` belongs to requester i.
- `Resultado`  out  2W  product; meaningful only while `Valid` is nonzero.
- `Erro`  out  1  high with `Valid` when the operation timed out.
- `Busy`  out  1  high in every state except IDLE.
- `Mul_St`  out  1  start pulse to the multiplier.
- `Mul_A`, `Mul_B`  out  W  operands to the multiplier; held stable from START until the end of DONE.
- `Mul_Done`  in  1  multiplier done level.
- `Mul_Idle`  in  1  multiplier idle level; informational, not used for sequencing.
- `Mul_Produto`  in  2W  multiplier product.

## Operation
- States: IDLE, START, WAIT, DONE. All outputs are registered.
- IDLE:
  - Arbitration runs only when any `Req` bit is high.
  - Winner: the first set bit scanning upward from `ptr`, wrapping modulo N.
  - At the edge: latch the winner's slices into `Mul_A`/`Mul_B`, latch the winner index into `id`, then go to START.
- START:
  - `Ack[id]`=1 and `Mul_St`=1 for exactly this cycle.
  - Clear `armed` and the timeout counter.
  - Go to WAIT.
- WAIT:
  - `armed` sets on the first cycle `Mul_Done`=0; this rejects a stale Done left over from the previous operation.
  - If `armed`=1 and `Mul_Done`=1: capture `Resultado`<=`Mul_Produto`, go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: `Resultado`<=0, set the error flag, go to DONE.
- DONE:
  - `Valid[id]`=1 and `Erro`=error flag, for one cycle.
  - `ptr`<=(`id`+1) mod N.
  - Go to IDLE.
- `Req` is sampled only in IDLE.
  - Once acknowledged, the requester must drop `Req`.
  - A `Req` still high when IDLE is re-entered counts as a new request.
- Requests arriving outside IDLE wait; they are not lost, because `Req` is a level.
- Simultaneous requests are served one per transaction in round-robin order. No requester waits more than N-1 transactions.
- Reset, asynchronous and valid in any state including mid-operation:
  - State=IDLE, `ptr`=0, `id`=0, counter=0, `armed`=0.
  - All outputs 0: `Ack`, `Valid`, `Resultado`, `Erro`, `Busy`, `Mul_St`, `Mul_A`, `Mul_B`.
  - Any in-flight result is discarded; the requester receives no `Valid`.

## Timing
- `Req` high at edge k (IDLE) -> `Ack` and `Mul_St` high during cycle k+1.
- First edge with `armed` and `Mul_Done` both high -> `Valid` high during the following cycle.
- Total latency: 3 + multiplier time cycles. Back-to-back transactions are separated by one IDLE cycle.
- Timeout path: `Valid` and `Erro` are high TIMEOUT+1 cycles after START.
- `Busy` rises with START and falls when IDLE is re-entered.

## Configuration
- `ARB_ZERO_BYPASS_EN` defined:
  - In IDLE, if the winner's A==0 or B==0, go directly to DONE. No `Mul_St` is issued.
  - `Ack[id]` and `Valid[id]` are both high in that single DONE cycle; `Resultado`=0, `Erro`=0.
  - `ptr` advances as normal.
- Not defined: zero operands follow the full START/WAIT path like any other operands.

## Test plan
- Single request, requester 0, A=12, B=10: `Ack[0]` pulse, one `Mul_St` pulse, `Valid[0]` with `Resultado`=120 and `Erro`=0.
- Requesters 1 and 3 request together with (200,3) and (7,9), `ptr`=0: requester 1 is served first (600), then requester 3 (63). `ptr` ends at 0.
- All four requesters held high for 8 transactions: grant order is 0,1,2,3,0,1,2,3. `Valid` is always one-hot.
- Model keeps `Mul_Done`=1 from the previous operation and delays the new Done: no early `Valid`. `Resultado` matches the new product, not the stale one.
- Model never raises `Mul_Done`, TIMEOUT=64: `Valid` and `Erro` are high with `Resultado`=0 exactly 65 cycles after START. The next request is served normally.
- Zero operand and reset:
  - A=12, B=0 with the macro defined: single-cycle `Ack`+`Valid`, `Resultado`=0, no `Mul_St`.
  - A=12, B=0 without the macro: the full path, `Resultado`=0.
  - `Rst_n` asserted during WAIT: all outputs 0 immediately, no `Valid`, and the state is IDLE after release.
